sha256_msg_schedule: RTL
========================

# sha256_msg_schedule

SHA-256 message-schedule generator feeding the round datapath in lockstep with the round counter. It accepts one 512-bit block as sixteen 32-bit words over a valid/ready handshake. It then presents the schedule words W_0..W_63 one per round step, expanding W_16..W_63 on the fly from a 16-word sliding window. The control unit drives `i_step` with the same enable it gives the round counter, so `o_t` matches the counter's address.

## Interface
Parameters:
- WORD_W, 32, schedule word width (fixed for SHA-256; not to be overridden)
- N_ROUNDS, 64, number of schedule words produced per block
- N_LOAD, 16, words loaded per block

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- i_start  in  1  begin loading a new block (sampled in IDLE only)
- i_clear  in  1  synchronous abort to IDLE (priority over all other inputs)
- i_in_valid  in  1  input word valid
- i_in_word  in  32  message word, big-endian order, word 0 first
- o_in_ready  out  1  block accepts input word this cycle
- i_step  in  1  advance to next round (consume current W_t)
- o_w  out  32  current schedule word W_t
- o_w_valid  out  1  o_w is a valid schedule word
- o_t  out  6  current round index t
- o_done  out  1  one-cycle pulse: W_63 consumed

## Operation
- States:
  - IDLE: all handshake outputs low.
  - LOAD: o_in_ready=1.
  - RUN: o_w_valid=1.
  - DONE: o_done=1, lasts exactly 1 cycle.
- Transitions:
  - IDLE: on i_start -> LOAD, with load index cleared to 0.
  - LOAD: every cycle with i_in_valid&&o_in_ready writes i_in_word into window slot [idx] and increments idx. The 16th accepted word moves the FSM to RUN with t=0.
  - RUN: i_step shifts the window by one and advances t. An i_step at t=63 moves the FSM to DONE.
  - DONE -> IDLE unconditionally.
- Window: win[0..15] holds W_t..W_{t+15}, and o_w = win[0].
- Shift on step:
  - win[i] <= win[i+1] for i = 0..14.
  - win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0], modulo 2^32 (carries discarded). This yields W_{t+16}.
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3; σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Expansion also runs on the final steps. Words computed beyond W_63 are don't-care and never made visible.
- i_start outside IDLE is ignored. i_in_valid outside LOAD is ignored and its word is not accepted. i_step outside RUN is ignored.
- i_clear in any state: next state IDLE, t and idx reset to 0, o_done suppressed. Window contents are don't-care.
- i_clear and i_start in the same IDLE cycle: i_clear wins and the FSM stays in IDLE.

## Timing
- Reset values: o_in_ready=0, o_w=0, o_w_valid=0, o_t=0, o_done=0, state=IDLE, window all zero.
- o_w, o_w_valid and o_t are registered or derived from registered state only. There is no combinational path from any input to any output.
- IDLE->LOAD: o_in_ready rises 1 cycle after i_start.
- LOAD->RUN: o_w_valid rises the cycle after the 16th handshake, with o_w=W_0 and o_t=0.
- Step latency: W_{t+1} appears on o_w the cycle after i_step. Back-to-back i_step gives one word per cycle.
- Minimum block time with continuous valid and step: 1 + 16 + 64 + 1 = 82 cycles from i_start to the return to IDLE.
- o_done asserts the cycle after the i_step at t=63. o_w_valid is low that cycle.
- Reset mid-operation: asynchronous return to the reset values; no partial block survives.

## Structure
- Shared package sha256_pkg: WORD_W, N_ROUNDS, N_LOAD, the state enum (IDLE, LOAD, RUN, DONE), and sigma0/sigma1 functions. The round datapath reuses the package.
- Sub-module sha256_sched_expand: combinational new-word calculation from win[0], win[1], win[9], win[14].

## Test plan
- Reset while in RUN at t=20 -> all outputs return to reset values immediately; o_t=0.
- Load the "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018) -> o_w sequence W0..W15 equals the loaded words, W16=0x61626380, W17=0x000F0000. All 64 words match the reference model.
- Continuous valid/step -> o_done pulses exactly once, at cycle 81 after i_start, and the FSM is back in IDLE at cycle 82.
- i_in_valid toggled randomly during LOAD, plus i_step stalled for 5 cycles at t=15 -> o_w holds steady during the stall and the sequence is unchanged.
- i_clear at t=40, then a new i_start and a second block -> the second block's W_0..W_63 are correct, with no contamination from the first.
- i_start and i_step asserted in IDLE and i_in_valid asserted in RUN -> all ignored, with no state change and no extra word accepted.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, schedule FSM states and sigma functions.
package sha256_pkg;
  localparam int WORD_W = 32;
  localparam int N_ROUNDS = 64;
  localparam int N_LOAD = 16;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
endpackage

// File: rtl/sha256_sched_expand.sv
// sha256_sched_expand: combinational W_{t+16} from the current sliding-window taps.
module sha256_sched_expand
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] w0,
  input  logic [WORD_W-1:0] w1,
  input  logic [WORD_W-1:0] w9,
  input  logic [WORD_W-1:0] w14,
  output logic [WORD_W-1:0] w_new
);
  assign w_new = sigma1(w14) + w9 + sigma0(w1) + w0;
endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: loads a 512-bit block and streams W_0..W_63 in lockstep with the round counter.
module sha256_msg_schedule #(
  parameter int WORD_W = 32,
  parameter int N_ROUNDS = 64,
  parameter int N_LOAD = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_clear,
  input  logic              i_in_valid,
  input  logic [WORD_W-1:0] i_in_word,
  output logic              o_in_ready,
  input  logic              i_step,
  output logic [WORD_W-1:0] o_w,
  output logic              o_w_valid,
  output logic [5:0]        o_t,
  output logic              o_done
);
  import sha256_pkg::state_t;
  import sha256_pkg::IDLE;
  import sha256_pkg::LOAD;
  import sha256_pkg::RUN;
  import sha256_pkg::DONE;
  state_t state;
  logic [3:0] idx;
  logic [5:0] t;
  logic [WORD_W-1:0] win [N_LOAD];
  logic [WORD_W-1:0] w_new;
  sha256_sched_expand u_expand (
    .w0   (win[0]),
    .w1   (win[1]),
    .w9   (win[9]),
    .w14  (win[14]),
    .w_new(w_new)
  );
  // t wraps to 0 on the final step, so o_t reads 0 while DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      t <= '0;
      for (int i = 0; i < N_LOAD; i++) win[i] <= '0;
    end else if (i_clear) begin
      state <= IDLE;
      idx <= '0;
      t <= '0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          state <= LOAD;
          idx <= '0;
        end
        LOAD: if (i_in_valid) begin
          win[idx] <= i_in_word;
          idx <= idx + 4'd1;
          if (idx == 4'(N_LOAD - 1)) begin
            state <= RUN;
            t <= '0;
          end
        end
        RUN: if (i_step) begin
          for (int i = 0; i < N_LOAD - 1; i++) win[i] <= win[i+1];
          win[N_LOAD-1] <= w_new;
          t <= t + 6'd1;
          if (t == 6'(N_ROUNDS - 1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign o_in_ready = state == LOAD;
  assign o_w_valid = state == RUN;
  assign o_done = state == DONE;
  assign o_w = win[0];
  assign o_t = t;
endmodule
